// File: rtl/seq_priority_encoder_pkg.sv
// Shared definitions for the registered priority encoder.
//   state_e : FSM states (IDLE waits for a pending request, PRESENT holds A/VALID)
//   N_DEF   : default number of request lines
//   CNT_W   : width of the completed-grant counter
package seq_encoder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int N_DEF = 8;
  localparam int CNT_W = 8;

endpackage

// File: rtl/seq_priority_encoder_prio_enc.sv
// Combinational priority encoder: index of the highest set bit of vec_i.
//   vec_i : N-bit input vector
//   idx_o : W-bit index of the highest set bit (0 when nothing is set)
//   any_o : high when any bit of vec_i is set
module prio_enc #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan: the last hit (highest index) overwrites earlier ones,
  // which gives line N-1 the top priority.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/seq_priority_encoder.sv
// Registered N-to-W priority encoder with falling-edge request capture and a
// VALID/ACK output handshake.
//   CLK, RST : clock, asynchronous active-high reset
//   EI_L     : active-low enable; gates capture and new launches
//   I_L      : active-low request lines, a falling edge pends a request
//   A, VALID : presented index and its valid flag, held until ACK
//   ACK      : consumer accepts A (ignored while VALID=0)
//   GS_L     : low when enabled and something is pending
//   EO_L     : low when enabled and nothing is pending
//   PEND     : pending-request vector
//   CNT      : completed grants, wraps modulo 2^CNT_W
module seq_priority_encoder
  import seq_encoder_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EI_L,
  input  logic [N-1:0]     I_L,
  output logic [W-1:0]     A,
  output logic             VALID,
  input  logic             ACK,
  output logic             GS_L,
  output logic             EO_L,
  output logic [N-1:0]     PEND,
  output logic [CNT_W-1:0] CNT
);

  logic [N-1:0]     iprev_q;
  logic [N-1:0]     p_q, p_d;
  logic [N-1:0]     fall, set_v, clr;
  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     top_idx;
  logic             any_p;
  logic             retire;

  // Retirement only happens from PRESENT, so ACK outside it is a no-op.
  assign retire = (state_q == PRESENT) && ACK;

  // Per-line edge capture and pending update. A same-cycle set overrides
  // the clear so a fresh fall on the line being retired is not lost.
  assign clr = retire ? (N'(1) << a_q) : '0;

  for (genvar i = 0; i < N; i++) begin : g_line
    assign fall[i]  = iprev_q[i] & ~I_L[i];
    assign set_v[i] = fall[i] & ~EI_L;
    assign p_d[i]   = (p_q[i] & ~clr[i]) | set_v[i];
  end

  prio_enc #(.N(N)) u_prio (
    .vec_i (p_q),
    .idx_o (top_idx),
    .any_o (any_p)
  );

  // Launch decisions use the registered pending vector, so a request seen
  // at edge k is presented after edge k+1.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!EI_L && any_p) begin
          a_d     = top_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Held regardless of EI_L or newer, higher-priority requests.
        if (ACK) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iprev_q <= '1;
      p_q     <= '0;
      state_q <= IDLE;
      a_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // IPREV tracks I_L even while disabled, so edges then are dropped.
      iprev_q <= I_L;
      p_q     <= p_d;
      state_q <= state_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A     = a_q;
  assign VALID = valid_q;
  assign PEND  = p_q;
  assign CNT   = cnt_q;
  assign GS_L  = ~(~EI_L & any_p);
  assign EO_L  = ~(~EI_L & ~any_p);

endmodule

// File: tb/tb_seq_priority_encoder.sv
module tb_seq_priority_encoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EI_L = 1'b0;
  logic [7:0] I_L = 8'hFF;
  logic       ACK = 1'b0;
  logic [2:0] A;
  logic       VALID, GS_L, EO_L;
  logic [7:0] PEND, CNT;

  seq_priority_encoder dut (
    .CLK(CLK), .RST(RST), .EI_L(EI_L), .I_L(I_L), .A(A), .VALID(VALID),
    .ACK(ACK), .GS_L(GS_L), .EO_L(EO_L), .PEND(PEND), .CNT(CNT)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference: request set, previous line levels, presented
  // grant and grant count, advanced once per clock edge.
  logic [7:0] m_p, m_prev;
  bit         m_valid;
  int         m_a, m_cnt;
  int         sb[$];     // expected grant indices, oldest first
  int         glog[$];   // grants observed by the monitor

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_p = 8'h00; m_prev = 8'hFF; m_valid = 0; m_a = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_step();
    logic [7:0] fall, p_old;
    p_old  = m_p;
    fall   = m_prev & ~I_L;
    m_prev = I_L;
    if (m_valid && ACK) m_p[m_a] = 1'b0;
    if (!EI_L) m_p = m_p | fall;
    if (m_valid) begin
      if (ACK) begin m_valid = 0; m_cnt = (m_cnt + 1) % 256; end
    end else if (!EI_L && p_old != 0) begin
      m_a = highest(p_old); m_valid = 1; sb.push_back(m_a);
    end
  endtask

  // Monitor: compares every cycle; pops the scoreboard on each new grant.
  initial begin
    bit pv = 0;
    int hold = 0;
    forever begin
      @(negedge CLK);
      if (RST) pv = 0;
      else begin
        chk("PEND", PEND, m_p);
        chk("VALID", VALID, m_valid);
        chk("CNT", CNT, m_cnt);
        chk("GS_L", GS_L, (!EI_L && m_p != 0) ? 0 : 1);
        chk("EO_L", EO_L, (!EI_L && m_p == 0) ? 0 : 1);
        if (VALID && !pv) begin
          if (sb.size() == 0) chk("grant_unexpected", 1, 0);
          else begin
            hold = sb.pop_front();
            chk("grant_A", A, hold);
          end
          glog.push_back(A);
        end else if (VALID) chk("A_stable", A, hold);
        pv = VALID;
      end
    end
  end

  task automatic cyc(input logic [7:0] il, input logic ei, input logic ack);
    @(negedge CLK); #2;
    I_L = il; EI_L = ei; ACK = ack;
    @(posedge CLK);
    model_step();
  endtask

  task automatic do_reset();
    RST = 1'b1; I_L = 8'hFF; EI_L = 1'b0; ACK = 1'b0;
    model_reset();
    glog.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK); #2;
    RST = 1'b0;
  endtask

  task automatic chk_log(input string name, input int n, input int e0, input int e1, input int e2);
    int e[3];
    e = '{e0, e1, e2};
    chk({name, "_count"}, glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++) chk({name, "_order"}, glog[i], e[i]);
  endtask

  initial begin
    logic [7:0] il;
    // Reset state
    do_reset();
    #1;
    chk("rst_VALID", VALID, 0); chk("rst_PEND", PEND, 0);
    chk("rst_GS_L", GS_L, 1);   chk("rst_EO_L", EO_L, 0);
    chk("rst_CNT", CNT, 0);

    // Single request on line 5
    cyc(8'hDF, 0, 0); #1;
    chk("single_PEND", PEND, 8'h20); chk("single_GS_L", GS_L, 0); chk("single_VALID0", VALID, 0);
    cyc(8'hDF, 0, 0); #1;
    chk("single_VALID", VALID, 1); chk("single_A", A, 5);
    cyc(8'hDF, 0, 1); #1;
    chk("single_PEND0", PEND, 0); chk("single_CNT", CNT, 1); chk("single_EO_L", EO_L, 0);
    chk("single_VALID_off", VALID, 0);

    // Simultaneous requests on 0, 4, 7 with ACK held high
    do_reset();
    repeat (7) cyc(8'h6E, 0, 1);
    #1;
    chk_log("simul", 3, 7, 4, 0);
    chk("simul_CNT", CNT, 3);

    // No preemption: 2 presented, 6 arrives before ACK
    do_reset();
    cyc(8'hFB, 0, 0); cyc(8'hFB, 0, 0);
    cyc(8'hBB, 0, 0); #1;
    chk("nopre_A", A, 2); chk("nopre_PEND", PEND, 8'h44);
    cyc(8'hBB, 0, 1); cyc(8'hBB, 0, 0); cyc(8'hBB, 0, 1);
    #1;
    chk_log("nopre", 2, 2, 6, 0);

    // Set wins over clear on the same bit
    do_reset();
    cyc(8'hF7, 0, 0); cyc(8'hF7, 0, 0);
    cyc(8'hFF, 0, 0); cyc(8'hF7, 0, 1); #1;
    chk("setwin_PEND3", PEND[3], 1); chk("setwin_VALID", VALID, 0);
    cyc(8'hF7, 0, 0); #1;
    chk("setwin_VALID2", VALID, 1); chk("setwin_A", A, 3);
    cyc(8'hF7, 0, 1);

    // Disabled: fall on line 1 is lost
    do_reset();
    cyc(8'hFD, 1, 0); #1;
    chk("dis_PEND", PEND, 0); chk("dis_GS_L", GS_L, 1); chk("dis_EO_L", EO_L, 1);
    cyc(8'hFD, 0, 0); cyc(8'hFD, 0, 0); #1;
    chk("dis_lost", PEND, 0); chk("dis_novalid", VALID, 0);

    // Asynchronous reset while a grant is presented
    do_reset();
    cyc(8'hEF, 0, 0); cyc(8'hEF, 0, 0);
    @(negedge CLK); #3;
    RST = 1'b1; I_L = 8'hFF; model_reset();
    #1;
    chk("arst_VALID", VALID, 0); chk("arst_PEND", PEND, 0); chk("arst_CNT", CNT, 0);
    @(posedge CLK); @(negedge CLK); #2;
    RST = 1'b0;

    // Randomized traffic
    il = 8'hFF;
    for (int n = 0; n < 600; n++) begin
      il = il ^ 8'($urandom & $urandom);
      cyc(il, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
    end
    for (int n = 0; n < 40; n++) cyc(8'hFF, 0, 1);
    @(negedge CLK); #1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
# seq_priority_encoder

Registered 8-to-3 priority encoder with request capture and a valid/ack output handshake, the encode-side counterpart of the dual 2-to-4 decoders. It captures falling edges on active-low request lines into a pending register and presents the highest-priority pending index as a binary code. It retires that index when the consumer acknowledges it. It sits between 74x148-style request sources and a decoder/consumer that turns the code back into a one-hot select.

## Interface
- N, 8: number of request lines; power of two, minimum 2.
- W, $clog2(N): code width, derived; not overridden.

Ports (clock and reset first):
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EI_L  in  1  active-low enable.
- I_L  in  N  active-low request lines, sampled on each rising edge.
- A  out  W  encoded index of the presented request, binary active-high.
- VALID  out  1  A holds a request awaiting acknowledge.
- ACK  in  1  consumer accepts A; meaningful only while VALID=1.
- GS_L  out  1  active-low "group select": enabled and any request pending.
- EO_L  out  1  active-low "enable out": enabled and nothing pending.
- PEND  out  N  pending-request vector P.
- CNT  out  8  count of completed grants; wraps 255 -> 0.

## Operation
- Edge capture:
  - Register IPREV holds the previous I_L sample.
  - fall[i] = IPREV[i] & ~I_L[i].
  - A line held low re-pends only after it returns high and falls again.
- Pending update (every edge): P <= (P & ~clr) | (fall & {N{~EI_L}}).
  - clr = onehot(A) when VALID & ACK, else 0.
  - If a new fall and the clear hit the same bit in the same cycle, the set wins.
- While EI_L=1, falls are not captured. IPREV still tracks I_L, so an edge during disable is lost.
- Priority: the highest set index of P wins, so line N-1 has the highest priority.
- FSM states:
  - IDLE: if EI_L=0 and P!=0, load A <= prio(P), set VALID <= 1, go to PRESENT. Otherwise hold, with VALID=0.
  - PRESENT: A and VALID are held stable regardless of EI_L or new requests. On ACK: clear P[A], CNT <= CNT+1, VALID <= 0, go to IDLE.
- A keeps its last value in IDLE and is don't-care while VALID=0. The bench checks A only while VALID=1.
- Flag outputs (combinational from EI_L and P):
  - GS_L = ~(~EI_L & |P).
  - EO_L = ~(~EI_L & ~|P).
- Reset values:
  - P=0, IPREV=all ones, A=0, VALID=0, CNT=0, state IDLE.
  - Hence GS_L=1 and EO_L=EI_L.
- Reset mid-transaction drops the presented and pending requests and does not count them.

## Timing
- I_L[i] sampled low at edge k (high at k-1): PEND[i] and GS_L valid after edge k. VALID=1 with A=i after edge k+1, provided nothing of higher priority is pending.
- ACK sampled high at edge m while VALID=1: VALID=0, PEND bit clear and CNT incremented after edge m.
- Earliest next VALID is after edge m+1. Maximum throughput is one grant per 2 cycles.
- ACK while VALID=0 is ignored.
- A higher-priority request arriving during PRESENT does not preempt. It is served in the next IDLE.
- EI_L rising during PRESENT: the transaction completes normally, and no new launch happens until EI_L=0.

## Structure
- Package seq_encoder_pkg:
  - state enum {IDLE, PRESENT}.
  - default N.
  - CNT width constant (8).
- Sub-module prio_enc: purely combinational, N-bit vector -> W-bit index of the highest set bit plus an any-set flag. It is reused by the FSM load path.
- The top level holds IPREV, P, FSM, A/VALID registers and CNT.

## Test plan
- Reset with EI_L=0 and I_L=8'hFF -> VALID=0, PEND=0, GS_L=1, EO_L=0, CNT=0.
- Single request: I_L[5] falls before edge k, then ACK one cycle after VALID -> PEND=8'h20 after k, VALID=1 and A=5 after k+1, then PEND=0, CNT=1, EO_L=0.
- Simultaneous requests: I_L=8'b0110_1110 in one cycle (lines 0, 4, 7 low), ACK held high -> grants in order A=7, 4, 0, VALID deasserting one cycle between grants, CNT=3.
- Priority and no preemption: request on line 2 presented, line 6 falls before ACK -> A stays 2 until ACK, next grant is A=6.
- Set-wins collision: line 3 presented, I_L[3] returns high then falls again, with the fall sampled on the ACK edge -> PEND[3]=1 after that edge, and A=3 is presented again.
- Enable/reset:
  - EI_L=1: line 1 falls -> PEND unchanged, GS_L=1, EO_L=1.
  - RST asserted while VALID=1 -> VALID=0, PEND=0, CNT unchanged from reset value 0 immediately (asynchronous, no clock edge needed).
